// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and the
// bit-timing helpers used by both the receive and transmit paths.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } rx_state_t;

   localparam int DATA_BITS = 8;

   function automatic logic [31:0] half_bit_count(input int clk_per_half_bit);
      return 32'(clk_per_half_bit - 1);
   endfunction

   function automatic logic [31:0] full_bit_count(input int clk_per_half_bit);
      return 32'(2 * clk_per_half_bit - 1);
   endfunction

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input; both flops
// reset to RESET_VAL so an idle-high line does not look like an edge.
module rx_sync #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rstn,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   // metastability filter chain
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/receiver.sv
// UART receive path: 8N1 (8E1 with RECEIVER_PARITY_EN defined), LSB first,
// bit-centre sampling, byte presented on a valid/ready output register.
module receiver
   import uart_pkg::*;
#(
   parameter int CLK_PER_HALF_BIT = 5208
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       UART_RX,
   output logic [7:0] data_recv,
   output logic       valid_recv,
   input  logic       ready_recv,
`ifdef RECEIVER_PARITY_EN
   output logic       parity_err,
`endif
   output logic       frame_err,
   output logic       overrun
);

   localparam logic [31:0] HALF_CNT = half_bit_count(CLK_PER_HALF_BIT);
   localparam logic [31:0] FULL_CNT = full_bit_count(CLK_PER_HALF_BIT);
   localparam logic [2:0]  LAST_IDX = 3'(DATA_BITS - 1);

   logic        rx_s;
   logic        rx_prev_q;
   rx_state_t   state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic [2:0]  bit_idx_q, bit_idx_d;
   logic [7:0]  shreg_q, shreg_d;
   logic        stop_ok_q, stop_ok_d;
   logic        frame_err_q, frame_err_d;
   logic [7:0]  data_q, data_d;
   logic        valid_q, valid_d;
   logic        overrun_q, overrun_d;
   logic        load_s;
`ifdef RECEIVER_PARITY_EN
   logic        par_q, par_d;
   logic        parity_err_q, parity_err_d;
`endif

   rx_sync #(.RESET_VAL(1'b1)) u_rx_sync (
      .clk  (clk),
      .rstn (rstn),
      .d_i  (UART_RX),
      .q_o  (rx_s)
   );

   // frame FSM: bit timing, sampling and shift register
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q + 32'd1;
      bit_idx_d   = bit_idx_q;
      shreg_d     = shreg_q;
      stop_ok_d   = 1'b0;
      frame_err_d = 1'b0;
`ifdef RECEIVER_PARITY_EN
      par_d       = par_q;
`endif
      case (state_q)
         IDLE: begin
            cnt_d = 32'd0;
            if (rx_prev_q && !rx_s) begin
               state_d = START;
            end else begin
               state_d = IDLE;
            end
         end
         START: begin
            if (cnt_q == HALF_CNT) begin
               if (!rx_s) begin
                  state_d   = DATA;
                  bit_idx_d = 3'd0;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               state_d = START;
            end
         end
         DATA: begin
            if (cnt_q == FULL_CNT) begin
               shreg_d = {rx_s, shreg_q[7:1]};
               cnt_d   = 32'd0;
               if (bit_idx_q == LAST_IDX) begin
`ifdef RECEIVER_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               state_d = DATA;
            end
         end
`ifdef RECEIVER_PARITY_EN
         PARITY: begin
            if (cnt_q == FULL_CNT) begin
               par_d   = rx_s;
               state_d = STOP;
            end else begin
               state_d = PARITY;
            end
         end
`endif
         STOP: begin
            // leave at the stop-bit centre so a following start edge is not missed
            if (cnt_q == FULL_CNT) begin
               state_d     = IDLE;
               stop_ok_d   = rx_s;
               frame_err_d = !rx_s;
            end else begin
               state_d = STOP;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (state_d != state_q) begin
         cnt_d = 32'd0;
      end else begin
         cnt_d = cnt_d;
      end
   end

   assign load_s = stop_ok_q && (!valid_q || ready_recv);

   // output register with valid/ready handshake and overrun detection
   always_comb begin
      data_d    = data_q;
      valid_d   = valid_q;
      overrun_d = stop_ok_q && !load_s;
      if (load_s) begin
         data_d  = shreg_q;
         valid_d = 1'b1;
      end else if (valid_q && ready_recv) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
`ifdef RECEIVER_PARITY_EN
      parity_err_d = stop_ok_q && (^{shreg_q, par_q});
`endif
   end

   // state and datapath registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rx_prev_q   <= 1'b1;
         state_q     <= IDLE;
         cnt_q       <= 32'd0;
         bit_idx_q   <= 3'd0;
         shreg_q     <= 8'd0;
         stop_ok_q   <= 1'b0;
         frame_err_q <= 1'b0;
         data_q      <= 8'd0;
         valid_q     <= 1'b0;
         overrun_q   <= 1'b0;
`ifdef RECEIVER_PARITY_EN
         par_q        <= 1'b0;
         parity_err_q <= 1'b0;
`endif
      end else begin
         rx_prev_q   <= rx_s;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_idx_q   <= bit_idx_d;
         shreg_q     <= shreg_d;
         stop_ok_q   <= stop_ok_d;
         frame_err_q <= frame_err_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         overrun_q   <= overrun_d;
`ifdef RECEIVER_PARITY_EN
         par_q        <= par_d;
         parity_err_q <= parity_err_d;
`endif
      end
   end

   assign data_recv  = data_q;
   assign valid_recv = valid_q;
   assign frame_err  = frame_err_q;
   assign overrun    = overrun_q;
`ifdef RECEIVER_PARITY_EN
   assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_receiver.sv
// Directed bench for the UART receiver with CLK_PER_HALF_BIT=4 (8 clocks/bit);
// covers the parity variant when RECEIVER_PARITY_EN is defined.
module tb_receiver;
   import uart_pkg::*;

   localparam int CPH      = 4;
   localparam int BIT_CLKS = 2 * CPH;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       UART_RX = 1'b1;
   logic       ready_recv = 1'b1;
   logic [7:0] data_recv;
   logic       valid_recv;
   logic       frame_err;
   logic       overrun;
`ifdef RECEIVER_PARITY_EN
   logic       parity_err;
`endif

   int errors = 0;
   int checks = 0;
   int fe_cnt = 0;
   int ov_cnt = 0;
   int pe_cnt = 0;
   logic [7:0] hs_q[$];

   receiver #(.CLK_PER_HALF_BIT(CPH)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .UART_RX    (UART_RX),
      .data_recv  (data_recv),
      .valid_recv (valid_recv),
      .ready_recv (ready_recv),
`ifdef RECEIVER_PARITY_EN
      .parity_err (parity_err),
`endif
      .frame_err  (frame_err),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   // event monitor, sampled away from the active edge
   always @(negedge clk) begin
      if (valid_recv && ready_recv) hs_q.push_back(data_recv);
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
`ifdef RECEIVER_PARITY_EN
      if (parity_err) pe_cnt++;
`endif
   end

   initial begin
      #300000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "simulation time budget exceeded");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic bit_out(input logic b);
      UART_RX = b;
      repeat (BIT_CLKS) @(negedge clk);
   endtask

   task automatic send(input logic [7:0] d, input logic stop_b);
      bit_out(1'b0);
      for (int i = 0; i < 8; i++) bit_out(d[i]);
`ifdef RECEIVER_PARITY_EN
      bit_out(^d);
`endif
      bit_out(stop_b);
      UART_RX = 1'b1;
   endtask

   function automatic logic [7:0] got(input int idx);
      if (hs_q.size() > idx) return hs_q[idx];
      else return 8'hxx;
   endfunction

   initial begin
      int n0, fe0, ov0;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_data", 32'(data_recv), 32'h00);
      chk("rst_valid", 32'(valid_recv), 32'h0);
      chk("rst_frame_err", 32'(frame_err), 32'h0);
      chk("rst_overrun", 32'(overrun), 32'h0);
      rstn = 1'b1;
      repeat (5) @(negedge clk);

      // single byte
      n0 = hs_q.size(); fe0 = fe_cnt; ov0 = ov_cnt;
      send(8'hA5, 1'b1);
      repeat (10) @(negedge clk);
      chk("t1_count", 32'(hs_q.size() - n0), 32'd1);
      chk("t1_data", 32'(got(n0)), 32'hA5);
      chk("t1_frame_err", 32'(fe_cnt - fe0), 32'd0);
      chk("t1_overrun", 32'(ov_cnt - ov0), 32'd0);

      // back-to-back frames with a one-bit stop
      n0 = hs_q.size(); fe0 = fe_cnt; ov0 = ov_cnt;
      send(8'h00, 1'b1);
      send(8'hFF, 1'b1);
      send(8'h55, 1'b1);
      repeat (10) @(negedge clk);
      chk("t2_count", 32'(hs_q.size() - n0), 32'd3);
      chk("t2_byte0", 32'(got(n0)), 32'h00);
      chk("t2_byte1", 32'(got(n0 + 1)), 32'hFF);
      chk("t2_byte2", 32'(got(n0 + 2)), 32'h55);
      chk("t2_errors", 32'(fe_cnt - fe0 + ov_cnt - ov0), 32'd0);

      // stop bit low
      n0 = hs_q.size(); fe0 = fe_cnt;
      send(8'h3C, 1'b0);
      repeat (10) @(negedge clk);
      chk("t3_frame_err", 32'(fe_cnt - fe0), 32'd1);
      chk("t3_no_byte", 32'(hs_q.size() - n0), 32'd0);
      chk("t3_valid", 32'(valid_recv), 32'h0);

      // overrun while the consumer stalls
      ready_recv = 1'b0;
      n0 = hs_q.size(); ov0 = ov_cnt;
      send(8'h11, 1'b1);
      send(8'h22, 1'b1);
      repeat (10) @(negedge clk);
      chk("t4_valid_held", 32'(valid_recv), 32'h1);
      chk("t4_data_held", 32'(data_recv), 32'h11);
      chk("t4_overrun", 32'(ov_cnt - ov0), 32'd1);
      ready_recv = 1'b1;
      repeat (5) @(negedge clk);
      chk("t4_drain_count", 32'(hs_q.size() - n0), 32'd1);
      chk("t4_drain_data", 32'(got(n0)), 32'h11);
      chk("t4_valid_low", 32'(valid_recv), 32'h0);

      // short low glitch on the idle line
      n0 = hs_q.size(); fe0 = fe_cnt;
      UART_RX = 1'b0;
      repeat (2) @(negedge clk);
      UART_RX = 1'b1;
      repeat (20) @(negedge clk);
      chk("t5_no_byte", 32'(hs_q.size() - n0), 32'd0);
      chk("t5_no_frame_err", 32'(fe_cnt - fe0), 32'd0);
      chk("t5_idle", 32'(dut.state_q), 32'(IDLE));

      // reset in the middle of a frame
      bit_out(1'b0);
      bit_out(1'b1);
      bit_out(1'b1);
      bit_out(1'b0);
      rstn = 1'b0;
      UART_RX = 1'b1;
      repeat (2) @(negedge clk);
      chk("t6_rst_data", 32'(data_recv), 32'h00);
      chk("t6_rst_valid", 32'(valid_recv), 32'h0);
      chk("t6_rst_flags", 32'({frame_err, overrun}), 32'h0);
      chk("t6_rst_state", 32'(dut.state_q), 32'(IDLE));
      rstn = 1'b1;
      repeat (5) @(negedge clk);
      n0 = hs_q.size(); fe0 = fe_cnt;
      send(8'h7E, 1'b1);
      repeat (10) @(negedge clk);
      chk("t6_count", 32'(hs_q.size() - n0), 32'd1);
      chk("t6_data", 32'(got(n0)), 32'h7E);
      chk("t6_frame_err", 32'(fe_cnt - fe0), 32'd0);

`ifdef RECEIVER_PARITY_EN
      // wrong even-parity bit: byte still delivered, parity_err pulses once
      chk("tp_clean_so_far", 32'(pe_cnt), 32'd0);
      n0 = hs_q.size();
      bit_out(1'b0);
      bit_out(1'b1);
      for (int i = 1; i < 8; i++) bit_out(1'b0);
      bit_out(1'b0);
      bit_out(1'b1);
      repeat (10) @(negedge clk);
      chk("tp_parity_err", 32'(pe_cnt), 32'd1);
      chk("tp_data", 32'(got(n0)), 32'h01);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
